// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Sequencer for the data-memory port behind the EX/MEM pipeline register.
// Each load/store held in EX/MEM becomes one req/ack transaction on a
// variable-latency memory bus. While the access is outstanding the front of
// the pipeline is frozen and bubbles are inserted into MEM/WB. A front-end
// flush that arrives during a stall is remembered and released once the
// stall ends.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a BUSY watchdog forces completion after TIMEOUT_CYCLES
//               BUSY cycles without i_ack, returning o_rdata=0 and pulsing
//               o_err together with o_rvalid.
//   undefined : BUSY waits indefinitely for i_ack; o_err is tied 0.
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_reset        synchronous active-low reset
//   i_mem_access   EX/MEM holds a valid load or store
//   i_memrw        1=store, 0=load
//   i_load_type    access size/sign code, forwarded as o_size
//   i_addr         EX/MEM ALU result (access address)
//   i_wdata        EX/MEM rs2 value (store data)
//   i_br_flush     front-end flush request from EX
//   i_ack          memory completes the current transaction
//   i_rdata        memory read data, valid with i_ack
//   o_req          transaction request
//   o_we           write enable for the transaction
//   o_size         latched i_load_type
//   o_addr         latched address
//   o_wdata        latched store data
//   o_stall        freeze PC, IF/ID, ID/EX, EX/MEM
//   o_flush_mw     insert bubble into MEM/WB
//   o_flush_front  effective flush to IF/ID, ID/EX
//   o_rdata        captured load data
//   o_rvalid       o_rdata valid this cycle
//   o_err          timeout pulse
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mem_access,
  input  logic              i_memrw,
  input  logic [2:0]        i_load_type,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_br_flush,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_req,
  output logic              o_we,
  output logic [2:0]        o_size,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_stall,
  output logic              o_flush_mw,
  output logic              o_flush_front,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic flush_pend;
  logic start;     // accepting a new access this cycle
  logic ack_done;  // normal completion this cycle
  logic timeout;   // forced completion this cycle

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] busy_cnt;

  // Counter holds the number of BUSY cycles already spent; expiry is the
  // TIMEOUT_CYCLES-th BUSY cycle. i_ack on that cycle still wins.
  assign timeout = (state == S_BUSY) && !i_ack &&
                   (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      busy_cnt <= '0;
    end else if (start) begin
      busy_cnt <= '0;
    end else if (state == S_BUSY) begin
      busy_cnt <= busy_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_mem_access) state_nxt = S_BUSY;
      S_BUSY:  if (i_ack || timeout) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode. The stall is combinational in IDLE so the
  // instruction in EX/MEM is held on the very cycle it is first seen.
  always_comb begin
    start    = 1'b0;
    ack_done = 1'b0;
    o_stall  = 1'b0;
    case (state)
      S_IDLE: begin
        start   = i_mem_access;
        o_stall = i_mem_access;
      end
      S_BUSY: begin
        o_stall  = 1'b1;
        ack_done = i_ack;
      end
      default: begin
        o_stall = 1'b0;
      end
    endcase
  end

  assign o_flush_mw    = o_stall;
  // A stall always wins; the flush waits in flush_pend until the stall ends.
  assign o_flush_front = (i_br_flush | flush_pend) & ~o_stall;

  // Request / response registers
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_req      <= 1'b0;
      o_we       <= 1'b0;
      o_size     <= 3'd0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_rdata    <= '0;
      o_rvalid   <= 1'b0;
      o_err      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (o_stall) begin
        flush_pend <= flush_pend | i_br_flush;
      end else begin
        flush_pend <= 1'b0;
      end

      if (start) begin
        o_req   <= 1'b1;
        o_we    <= i_memrw;
        o_size  <= i_load_type;
        o_addr  <= i_addr;
        o_wdata <= i_wdata;
      end

      if (ack_done) begin
        o_req    <= 1'b0;
        o_rvalid <= 1'b1;
        if (!o_we) begin
          o_rdata <= i_rdata;
        end
      end else if (timeout) begin
        o_req    <= 1'b0;
        o_rvalid <= 1'b1;
        o_rdata  <= '0;
        o_err    <= 1'b1;
      end

      if (state == S_RESP) begin
        o_rvalid <= 1'b0;
        o_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed vector table for the documented scenarios, followed by a random
// phase. Every cycle is also checked against a transaction-level reference
// model of the memory access sequencing.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_mem_access;
  logic        i_memrw;
  logic [2:0]  i_load_type;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_br_flush;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        o_req, o_we, o_stall, o_flush_mw, o_flush_front, o_rvalid, o_err;
  logic [2:0]  o_size;
  logic [31:0] o_addr, o_wdata, o_rdata;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_mem_access(i_mem_access),
    .i_memrw(i_memrw), .i_load_type(i_load_type), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_br_flush(i_br_flush), .i_ack(i_ack),
    .i_rdata(i_rdata), .o_req(o_req), .o_we(o_we), .o_size(o_size),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_stall(o_stall),
    .o_flush_mw(o_flush_mw), .o_flush_front(o_flush_front),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one outstanding access at most, then one response cycle.
  bit          m_pending, m_resp, m_fp;
  bit          m_req, m_we, m_rvalid, m_err;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_wait;

  // Output values sampled mid-cycle by apply()
  logic        s_stall, s_mw, s_ff, s_req, s_we, s_rvalid, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;

  task automatic model_reset();
    m_pending = 0; m_resp = 0; m_fp = 0;
    m_req = 0; m_we = 0; m_rvalid = 0; m_err = 0;
    m_size = '0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
  endtask

  // Drive one cycle (called at a negedge), check outputs, advance the model.
  task automatic apply(input logic rstn, acc, rw, input logic [2:0] sz,
                       input logic [31:0] ad, wd, input logic br, ack,
                       input logic [31:0] rd);
    logic         idle, e_stall, e_ff;
    logic [105:0] act, exp;
    i_reset = rstn; i_mem_access = acc; i_memrw = rw; i_load_type = sz;
    i_addr = ad; i_wdata = wd; i_br_flush = br; i_ack = ack; i_rdata = rd;
    #1;
    idle    = !m_pending && !m_resp;
    e_stall = m_pending || (idle && acc);
    e_ff    = (br || m_fp) && !e_stall;
    s_stall = o_stall; s_mw = o_flush_mw; s_ff = o_flush_front; s_req = o_req;
    s_we = o_we; s_rvalid = o_rvalid; s_err = o_err;
    s_addr = o_addr; s_wdata = o_wdata; s_rdata = o_rdata;
    act = {o_stall, o_flush_mw, o_flush_front, o_req, o_we, o_size,
           o_addr, o_wdata, o_rdata, o_rvalid, o_err};
    exp = {e_stall, e_stall, e_ff, m_req, m_we, m_size,
           m_addr, m_wdata, m_rdata, m_rvalid, m_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model cyc=%0d act=%h exp=%h", cyc, act, exp);
    end
    @(posedge i_clk);
    if (!rstn) begin
      model_reset();
    end else begin
      m_fp = e_stall ? (m_fp || br) : 1'b0;
      if (m_resp) begin
        m_resp = 0; m_rvalid = 0; m_err = 0;
      end else if (m_pending) begin
        if (ack) begin
          m_pending = 0; m_req = 0; m_rvalid = 1; m_resp = 1;
          if (!m_we) m_rdata = rd;
        end else if (TO_EN && m_wait == TO - 1) begin
          m_pending = 0; m_req = 0; m_rvalid = 1; m_resp = 1;
          m_rdata = '0; m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (acc) begin
        m_pending = 1; m_req = 1; m_we = rw; m_size = sz;
        m_addr = ad; m_wdata = wd; m_wait = 0;
      end
    end
    cyc++;
    @(negedge i_clk);
  endtask

  typedef struct {
    logic        rstn, acc, rw, br, ack;
    logic [31:0] addr, wdata, rdata;
    logic        e_stall, e_req, e_we, e_rvalid, e_ff, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  function automatic vec_t mk(logic rstn, acc, rw, logic [31:0] addr, wdata,
                              logic br, ack, logic [31:0] rdata,
                              logic es, er, ew, ev, ef, ee,
                              logic [31:0] ea, ewd, erd);
    vec_t v;
    v.rstn = rstn; v.acc = acc; v.rw = rw; v.addr = addr; v.wdata = wdata;
    v.br = br; v.ack = ack; v.rdata = rdata;
    v.e_stall = es; v.e_req = er; v.e_we = ew; v.e_rvalid = ev; v.e_ff = ef;
    v.e_err = ee; v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [104:0] ta, te;
    // reset state
    tbl.push_back(mk(0,0,0,0,0,0,0,0,             0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 0,0,0));
    // load 0x100, ack on third BUSY cycle
    tbl.push_back(mk(1,1,0,'h100,0,0,0,0,         1,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,'h100,0,0,0,0,         1,1,0,0,0,0, 'h100,0,0));
    tbl.push_back(mk(1,1,0,'h100,0,0,0,0,         1,1,0,0,0,0, 'h100,0,0));
    tbl.push_back(mk(1,1,0,'h100,0,0,1,'hDEADBEEF,1,1,0,0,0,0, 'h100,0,0));
    tbl.push_back(mk(1,1,0,'h100,0,0,0,0,         0,0,0,1,0,0, 'h100,0,'hDEADBEEF));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 'h100,0,'hDEADBEEF));
    // store 0x20 / 0x12345678, ack in first BUSY cycle, rdata untouched
    tbl.push_back(mk(1,1,1,'h20,'h12345678,0,0,0,          1,0,0,0,0,0, 'h100,0,'hDEADBEEF));
    tbl.push_back(mk(1,1,1,'h20,'h12345678,0,1,'hCAFEF00D, 1,1,1,0,0,0, 'h20,'h12345678,'hDEADBEEF));
    tbl.push_back(mk(1,1,1,'h20,'h12345678,0,0,0,          0,0,1,1,0,0, 'h20,'h12345678,'hDEADBEEF));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                      0,0,1,0,0,0, 'h20,'h12345678,'hDEADBEEF));
    // flush pulse during stall is deferred to the RESP cycle
    tbl.push_back(mk(1,1,0,'h40,0,0,0,0,          1,0,1,0,0,0, 'h20,'h12345678,'hDEADBEEF));
    tbl.push_back(mk(1,1,0,'h40,0,1,0,0,          1,1,0,0,0,0, 'h40,0,'hDEADBEEF));
    tbl.push_back(mk(1,1,0,'h40,0,0,1,'h55AA55AA, 1,1,0,0,0,0, 'h40,0,'hDEADBEEF));
    tbl.push_back(mk(1,1,0,'h40,0,0,0,0,          0,0,0,1,1,0, 'h40,0,'h55AA55AA));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 'h40,0,'h55AA55AA));
    tbl.push_back(mk(1,0,0,0,0,1,0,0,             0,0,0,0,1,0, 'h40,0,'h55AA55AA));
    // reset while BUSY, then a normal access
    tbl.push_back(mk(1,1,0,'h80,0,0,0,0,          1,0,0,0,0,0, 'h40,0,'h55AA55AA));
    tbl.push_back(mk(1,1,0,'h80,0,0,0,0,          1,1,0,0,0,0, 'h80,0,'h55AA55AA));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,             1,1,0,0,0,0, 'h80,0,'h55AA55AA));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,'h84,0,0,0,0,          1,0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,1,0,'h84,0,0,1,'h0BADF00D, 1,1,0,0,0,0, 'h84,0,0));
    tbl.push_back(mk(1,1,0,'h84,0,0,0,0,          0,0,0,1,0,0, 'h84,0,'h0BADF00D));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 'h84,0,'h0BADF00D));
    // back-to-back loads: stall 1,1,0,1,1,0
    tbl.push_back(mk(1,1,0,'h10,0,0,0,0,          1,0,0,0,0,0, 'h84,0,'h0BADF00D));
    tbl.push_back(mk(1,1,0,'h10,0,0,1,'h11111111, 1,1,0,0,0,0, 'h10,0,'h0BADF00D));
    tbl.push_back(mk(1,1,0,'h10,0,0,0,0,          0,0,0,1,0,0, 'h10,0,'h11111111));
    tbl.push_back(mk(1,1,0,'h14,0,0,0,0,          1,0,0,0,0,0, 'h10,0,'h11111111));
    tbl.push_back(mk(1,1,0,'h14,0,0,1,'h22222222, 1,1,0,0,0,0, 'h14,0,'h11111111));
    tbl.push_back(mk(1,1,0,'h14,0,0,0,0,          0,0,0,1,0,0, 'h14,0,'h22222222));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 'h14,0,'h22222222));
`ifdef MEM_TIMEOUT_EN
    // no ack: forced completion after TO BUSY cycles
    tbl.push_back(mk(1,1,0,'h200,0,0,0,0,         1,0,0,0,0,0, 'h14,0,'h22222222));
    for (int k = 0; k < TO; k++)
      tbl.push_back(mk(1,1,0,'h200,0,0,0,0,       1,1,0,0,0,0, 'h200,0,'h22222222));
    tbl.push_back(mk(1,1,0,'h200,0,0,0,0,         0,0,0,1,0,1, 'h200,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,             0,0,0,0,0,0, 'h200,0,0));
`endif

    // initial reset without checking (outputs are unknown before it)
    i_reset = 0; i_mem_access = 0; i_memrw = 0; i_load_type = 0; i_addr = 0;
    i_wdata = 0; i_br_flush = 0; i_ack = 0; i_rdata = 0;
    repeat (2) @(posedge i_clk);
    model_reset();
    @(negedge i_clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rstn, tbl[i].acc, tbl[i].rw, 3'd2, tbl[i].addr, tbl[i].wdata,
            tbl[i].br, tbl[i].ack, tbl[i].rdata);
      ta = {s_stall, s_mw, s_ff, s_req, s_we, s_rvalid, s_err, s_addr, s_wdata, s_rdata};
      te = {tbl[i].e_stall, tbl[i].e_stall, tbl[i].e_ff, tbl[i].e_req, tbl[i].e_we,
            tbl[i].e_rvalid, tbl[i].e_err, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_rdata};
      n_cmp++;
      if (ta !== te) begin
        n_bad++;
        $display("FAIL vec%0d act=%h exp=%h", i, ta, te);
      end
    end

    // random phase against the reference model
    for (int r = 0; r < 800; r++) begin
      apply(($urandom_range(0, 59) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), $urandom, $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencer for the data-memory port behind the EX/MEM pipeline register.
- Turns each load/store held in EX/MEM into a req/ack transaction on a variable-latency data-memory bus.
- Stalls the front of the pipeline and inserts bubbles into MEM/WB until the access completes.
- Defers any front-end flush that arrives during a stall.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 255, max BUSY cycles before forced completion (MEM_TIMEOUT_EN only)

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  synchronous active-low reset
i_mem_access  input  1  EX/MEM holds a valid load or store
i_memrw  input  1  1=store, 0=load
i_load_type  input  3  access size/sign code from EX/MEM, forwarded unchanged
i_addr  input  ADDR_W  EX/MEM ALU result
i_wdata  input  DATA_W  EX/MEM rs2 value
i_br_flush  input  1  front-end flush request from EX
i_ack  input  1  memory completes current transaction
i_rdata  input  DATA_W  memory read data, valid with i_ack
o_req  output  1  transaction request
o_we  output  1  write enable for the transaction
o_size  output  3  latched i_load_type
o_addr  output  ADDR_W  latched address
o_wdata  output  DATA_W  latched store data
o_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
o_flush_mw  output  1  insert bubble into MEM/WB
o_flush_front  output  1  effective flush to IF/ID, ID/EX
o_rdata  output  DATA_W  captured load data
o_rvalid  output  1  o_rdata valid this cycle
o_err  output  1  timeout pulse

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is synchronous and active-low.
- Reset values (i_reset=0 at a rising edge): state=IDLE; o_req, o_we, o_size, o_addr, o_wdata, o_rdata, o_rvalid, o_err, flush_pend all 0.
- Reset mid-transaction: o_req drops next cycle; the memory side tolerates the abandoned request.
- FSM state IDLE:
  - If i_mem_access=1: o_stall=1 combinationally; latch addr, wdata, we=i_memrw, size; o_req<=1; go to BUSY.
  - Otherwise o_stall=0.
- FSM state BUSY:
  - o_stall=1 and o_req=1 are held; the latched request fields are stable.
  - Transfer completes on the edge where o_req & i_ack.
  - On completion: o_req<=0; o_rdata<=i_rdata if load, unchanged if store; o_rvalid<=1; go to RESP.
  - i_ack while not in BUSY is ignored.
- FSM state RESP (exactly 1 cycle):
  - o_stall=0, o_rvalid=1. The pipeline advances and MEM/WB captures the completed instruction with o_rdata.
  - i_mem_access is ignored here (same instruction still present).
  - Next state IDLE; o_rvalid<=0.
- o_flush_mw = o_stall.
- Latency:
  - Memory acking in the first BUSY cycle gives 2 stall cycles plus the RESP cycle.
  - Each extra wait cycle adds one stall cycle.
  - Back-to-back accesses: the next access is detected in IDLE on the cycle after RESP.
- Deferred flush:
  - flush_pend<=1 when i_br_flush & o_stall; cleared when o_stall=0.
  - o_flush_front = (i_br_flush | flush_pend) & ~o_stall.
  - A stall always wins over a flush; a flush is never lost.
- Stores and loads wait for i_ack identically; stores never update o_rdata.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit+ counter (sized to hold TIMEOUT_CYCLES) clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without i_ack: o_req<=0, o_rdata<=0, o_err pulses 1 cycle together with o_rvalid, go to RESP.
  - i_ack on the expiry cycle takes precedence (normal completion, no o_err).
- Undefined: no counter; BUSY waits indefinitely; o_err tied 0.

Test Plan:
- Load to addr 0x100, i_ack asserted 3 cycles after o_req, i_rdata=0xDEADBEEF -> o_stall high 4 cycles, then o_rvalid=1 with o_rdata=0xDEADBEEF for 1 cycle, o_we=0, o_addr=0x100 stable throughout.
- Store addr 0x20 data 0x12345678, ack after 1 cycle -> o_we=1, o_wdata=0x12345678 held until ack, o_rdata unchanged, 2 stall cycles.
- Two consecutive loads, ack on first BUSY cycle each -> stall pattern 1,1,0,1,1,0; each o_rdata matches its own i_rdata.
- i_br_flush pulsed 1 cycle mid-stall -> o_flush_front=0 while stalled, =1 in the RESP cycle, flush_pend clears.
- i_reset=0 for one cycle while in BUSY -> next cycle o_req=0, o_stall=0, state IDLE; a later access proceeds normally.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> o_req drops after 4 BUSY cycles, o_err=1 and o_rvalid=1 with o_rdata=0 for 1 cycle.
